// File: rtl/db15_joy_responder.sv
// db15_joy_responder: DB15 adapter emulation that latches two 12-bit joystick words and shifts them to the host.
// Host pins are synchronised into clk and edge-detected; the wire level is inverted (pressed = 0).
module db15_joy_responder #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [11:0] joy1,
  input  logic [11:0] joy2,
  input  logic        joy_load,
  input  logic        joy_clk,
  input  logic        ser_in,
  output logic        joy_data,
  output logic [4:0]  bit_cnt,
  output logic        frame_done,
  output logic        overrun
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
  typedef enum logic [1:0] {IDLE, LOADED, SHIFTING, DONE} state_t;
  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  load_sync_q, clk_sync_q;
  logic                    clk_prev_q;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    done_q, done_d, ovr_q, ovr_d;
  logic                    load_s, clk_s, clk_rise;
  assign load_s     = load_sync_q[SYNC_STAGES-1];
  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign clk_rise   = clk_s & ~clk_prev_q;
  assign joy_data   = shreg_q[0];
  assign bit_cnt    = 5'(cnt_q);
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  // A low load level overrides any concurrent shift edge.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (!load_s) begin
      state_d = LOADED;
      shreg_d = FRAME_BITS'(~{joy2, joy1});
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (state_q == LOADED) begin
      state_d = SHIFTING;
    end else if (clk_rise) begin
      shreg_d = {(state_q == IDLE) ? 1'b1 : ser_in, shreg_q[FRAME_BITS-1:1]};
      if (state_q == SHIFTING) begin
        cnt_d   = cnt_q + 1'b1;
        done_d  = (cnt_d == FULL);
        state_d = done_d ? DONE : SHIFTING;
      end
      ovr_d = ovr_q | (state_q == DONE);
    end
  end
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      load_sync_q <= '1;
      clk_sync_q  <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      shreg_q     <= '1;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], joy_load};
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk};
      clk_prev_q  <= clk_s;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
    end
  end
endmodule

// File: tb/tb_db15_joy_responder.sv
// tb_db15_joy_responder: directed and randomized host transactions checked against a queue model of the wire.
module tb_db15_joy_responder;
  localparam int SS = 2;
  localparam int H  = SS + 2;
  logic        clk = 1'b0, RESET = 1'b1;
  logic [11:0] joy1 = '0, joy2 = '0;
  logic        joy_load = 1'b1, joy_clk = 1'b0, ser_in = 1'b1;
  logic        joy_data, frame_done, overrun;
  logic [4:0]  bit_cnt;
  int          cmp = 0, bad = 0, fd_total = 0;
  logic        q[$];
  int          n;
  bit          loaded, ovr;
  logic [23:0] seen;
  db15_joy_responder #(.FRAME_BITS(24), .SYNC_STAGES(SS)) dut (
    .clk(clk), .RESET(RESET), .joy1(joy1), .joy2(joy2), .joy_load(joy_load),
    .joy_clk(joy_clk), .ser_in(ser_in), .joy_data(joy_data), .bit_cnt(bit_cnt),
    .frame_done(frame_done), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) fd_total++;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    cmp++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic wait_n(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic model_reset();
    q.delete();
    repeat (24) q.push_back(1'b1);
    n = 0; loaded = 0; ovr = 0;
  endtask
  task automatic model_load(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] w;
    w = ~{b, a};
    q.delete();
    for (int i = 0; i < 24; i++) q.push_back(w[i]);
    n = 0; ovr = 0; loaded = 1;
  endtask
  task automatic do_load(input logic [11:0] a, input logic [11:0] b, input int hold);
    joy1 = a; joy2 = b; joy_load = 1'b0;
    wait_n(hold);
    model_load(a, b);
    chk("load_data", joy_data, q[0]);
    chk("load_cnt", bit_cnt, 0);
    chk("load_ovr", overrun, 0);
    joy_load = 1'b1;
    wait_n(H);
  endtask
  task automatic shift(input logic s);
    int f0;
    logic fd_exp;
    chk("pre_data", joy_data, q[0]);
    ser_in = s; f0 = fd_total; fd_exp = loaded && n == 23;
    joy_clk = 1'b1;
    wait_n(H);
    void'(q.pop_front());
    q.push_back(loaded ? s : 1'b1);
    if (loaded) begin
      if (n == 24) ovr = 1; else n++;
    end
    joy_clk = 1'b0;
    wait_n(H);
    chk("post_data", joy_data, q[0]);
    chk("bit_cnt", bit_cnt, n);
    chk("overrun", overrun, ovr);
    chk("frame_done", fd_total - f0, fd_exp);
  endtask
  initial begin
    int f0;
    model_reset();
    wait_n(3);
    RESET = 1'b0;
    wait_n(2);
    chk("rst_data", joy_data, 1);
    chk("rst_cnt", bit_cnt, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovr", overrun, 0);
    f0 = fd_total;
    repeat (10) shift(1'($urandom_range(0, 1)));
    chk("idle_no_done", fd_total - f0, 0);
    joy1 = 12'h801; joy2 = 12'h010;
    joy_load = 1'b0; joy_clk = 1'b1;
    wait_n(SS);
    chk("lat_early", joy_data, 1);
    wait_n(1);
    chk("lat_edge", joy_data, 0);
    model_load(12'h801, 12'h010);
    wait_n(H);
    chk("collide_cnt", bit_cnt, 0);
    chk("collide_data", joy_data, q[0]);
    joy_clk = 1'b0;
    wait_n(H);
    joy_load = 1'b1;
    wait_n(H);
    do_load(12'h801, 12'h010, 8);
    f0 = fd_total;
    for (int i = 0; i < 24; i++) begin
      seen[i] = joy_data;
      shift(1'b0);
    end
    chk("wire_801_010", seen, 24'hFEF7FE);
    chk("frame_one_done", fd_total - f0, 1);
    chk("frame_cnt", bit_cnt, 24);
    chk("fill_data", joy_data, 0);
    shift(1'b0);
    shift(1'b0);
    chk("ovr_set", overrun, 1);
    chk("ovr_cnt_hold", bit_cnt, 24);
    do_load(12'($urandom), 12'($urandom), 8);
    do_load(12'h0F0, 12'($urandom), 8);
    repeat (7) shift(1'($urandom_range(0, 1)));
    chk("pre_rst_data", joy_data, 0);
    chk("pre_rst_cnt", bit_cnt, 7);
    RESET = 1'b1;
    #1;
    chk("async_rst_data", joy_data, 1);
    chk("async_rst_cnt", bit_cnt, 0);
    chk("async_rst_ovr", overrun, 0);
    wait_n(2);
    RESET = 1'b0;
    model_reset();
    wait_n(2);
    do_load(12'($urandom), 12'($urandom), 8);
    repeat (24) shift(1'($urandom_range(0, 1)));
    do_load(12'h000, 12'($urandom), 8);
    repeat (5) shift(1'($urandom_range(0, 1)));
    joy1 = 12'hFFF;
    repeat (19) shift(1'($urandom_range(0, 1)));
    repeat (3) begin
      do_load(12'($urandom), 12'($urandom), $urandom_range(H, 10));
      repeat (24 + $urandom_range(0, 3)) shift(1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
